// File: rtl/lotr_pkg.sv
// Shared LOTR ring fabric types: ring message layout, opcodes, and
// destination-field positions used by ring stops.
package lotr_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_RESP  = 2'd2,
    OP_INV   = 2'd3
  } t_opcode;

  localparam int unsigned RING_ID_MSB     = 31;
  localparam int unsigned RING_ID_LSB     = 24;
  localparam int unsigned RING_REQ_ID_LSB = 2;

  typedef struct packed {
    logic        valid;
    logic [9:0]  requestor;
    t_opcode     opcode;
    logic [31:0] address;
    logic [31:0] data;
  } t_ring_msg;

  // Destination tile of a ring message: address high byte, or requestor[9:2]
  function automatic logic [7:0] ring_dest(input t_ring_msg m, input bit use_req);
    if (use_req) ring_dest = m.requestor[RING_REQ_ID_LSB +: 8];
    else         ring_dest = m.address[RING_ID_MSB:RING_ID_LSB];
  endfunction

endpackage

// File: rtl/lotr_ring_ej_fifo.sv
// Ejection FIFO for a ring stop. Power-of-two depth, pointers carry one
// extra wrap bit so full/empty are distinguished without a counter.
// Push while full is legal only when a pop happens the same cycle.
module lotr_ring_ej_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_pop;

  assign valid   = (wr_ptr != rd_ptr);
  assign full    = ((wr_ptr - rd_ptr) == (AW+1)'(DEPTH));
  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop & valid;

  // Pointer update; reset empties the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/lotr_ring_stop.sv
// LOTR ring stop: Q500->Q502 ring pipeline with local ejection into a FIFO
// (bounce when full) and round-robin injection from NUM_LCL local channels
// into free slots.
// Optional macro LOTR_RING_STOP_PERF_EN adds saturating 16-bit counters
// PerfInjCnt / PerfEjCnt / PerfBounceCnt.
module lotr_ring_stop
  import lotr_pkg::*;
#(
  parameter int unsigned NUM_LCL         = 4,
  parameter int unsigned EJ_DEPTH        = 4,
  parameter bit          MATCH_REQUESTOR = 1'b0
) (
  input  logic                       QClk,
  input  logic                       RstQnnnL,
  input  logic [7:0]                 CoreID,
  input  logic                       RingInValidQ500H,
  input  logic [9:0]                 RequestorQ500H,
  input  t_opcode                    OpcodeQ500H,
  input  logic [31:0]                AddressQ500H,
  input  logic [31:0]                DataQ500H,
  output logic                       RingOutValidQ502H,
  output logic [9:0]                 RequestorQ502H,
  output t_opcode                    OpcodeQ502H,
  output logic [31:0]                AddressQ502H,
  output logic [31:0]                DataQ502H,
  input  logic [NUM_LCL-1:0]         LclValid,
  input  t_ring_msg [NUM_LCL-1:0]    LclMsg,
  output logic [NUM_LCL-1:0]         LclReady,
  output logic                       EjValid,
  output t_ring_msg                  EjMsg,
  input  logic                       EjReady,
  output logic                       EjFull
`ifdef LOTR_RING_STOP_PERF_EN
  ,
  output logic [15:0]                PerfInjCnt,
  output logic [15:0]                PerfEjCnt,
  output logic [15:0]                PerfBounceCnt
`endif
);

  localparam int unsigned PTR_W = (NUM_LCL > 1) ? $clog2(NUM_LCL) : 1;

  t_ring_msg        ring_in;
  t_ring_msg        slot_q501;
  t_ring_msg        slot_q502;
  t_ring_msg        slot_nxt;
  logic             match;
  logic             ej_pop;
  logic             ej_push;
  logic             slot_free;
  logic             gnt_vld;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] cand;
  int unsigned      cand_sum;

  assign ring_in = '{valid:     RingInValidQ500H,
                     requestor: RequestorQ500H,
                     opcode:    OpcodeQ500H,
                     address:   AddressQ500H,
                     data:      DataQ500H};

  // Q501 stage: capture upstream slot
  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) slot_q501 <= '0;
    else           slot_q501 <= ring_in;
  end

  // Eject only when the FIFO has room after this cycle's pop; else bounce
  assign match     = slot_q501.valid && (ring_dest(slot_q501, MATCH_REQUESTOR) == CoreID);
  assign ej_pop    = EjValid & EjReady;
  assign ej_push   = match & (~EjFull | ej_pop);
  assign slot_free = ~slot_q501.valid | ej_push;

  // Round-robin pick: first requesting channel at or after rr_ptr
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    cand     = '0;
    cand_sum = 0;
    for (int unsigned i = 0; i < NUM_LCL; i++) begin
      cand_sum = 32'(rr_ptr) + i;
      if (cand_sum >= NUM_LCL) cand_sum = cand_sum - NUM_LCL;
      cand = PTR_W'(cand_sum);
      if (!gnt_vld && LclValid[cand] && slot_free && RstQnnnL) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // One-hot grant to the winning channel
  always_comb begin
    LclReady = '0;
    if (gnt_vld) LclReady[gnt_idx] = 1'b1;
  end

  // Round-robin pointer advances past the winner only on a grant
  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL)    rr_ptr <= '0;
    else if (gnt_vld) rr_ptr <= (gnt_idx == PTR_W'(NUM_LCL - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // Q502 slot contents: injected message, forwarded/bounced message, or empty
  always_comb begin
    slot_nxt       = slot_q501;
    slot_nxt.valid = slot_q501.valid & ~ej_push;
    if (gnt_vld) begin
      slot_nxt       = LclMsg[gnt_idx];
      slot_nxt.valid = 1'b1;
    end
  end

  // Q502 stage: register the decided slot
  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) slot_q502 <= '0;
    else           slot_q502 <= slot_nxt;
  end

  assign RingOutValidQ502H = slot_q502.valid;
  assign RequestorQ502H    = slot_q502.requestor;
  assign OpcodeQ502H       = slot_q502.opcode;
  assign AddressQ502H      = slot_q502.address;
  assign DataQ502H         = slot_q502.data;

  lotr_ring_ej_fifo #(
    .DEPTH (EJ_DEPTH),
    .WIDTH ($bits(t_ring_msg))
  ) u_ej_fifo (
    .clk     (QClk),
    .rst_n   (RstQnnnL),
    .push    (ej_push),
    .wr_data (slot_q501),
    .pop     (ej_pop),
    .rd_data (EjMsg),
    .valid   (EjValid),
    .full    (EjFull)
  );

`ifdef LOTR_RING_STOP_PERF_EN
  logic bounce;
  assign bounce = match & ~ej_push;

  // Saturating event counters
  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      PerfInjCnt    <= '0;
      PerfEjCnt     <= '0;
      PerfBounceCnt <= '0;
    end else begin
      if (gnt_vld && (PerfInjCnt != '1))    PerfInjCnt    <= PerfInjCnt + 16'd1;
      if (ej_push && (PerfEjCnt != '1))     PerfEjCnt     <= PerfEjCnt + 16'd1;
      if (bounce && (PerfBounceCnt != '1))  PerfBounceCnt <= PerfBounceCnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lotr_ring_stop.sv
// Scoreboard bench for lotr_ring_stop: a driver applies directed and random
// traffic and pushes the reference model's expected per-cycle outputs into
// a queue; a monitor pops one record per cycle and compares.
module tb_lotr_ring_stop;
  import lotr_pkg::*;

  localparam int unsigned NUM_LCL  = 4;
  localparam int unsigned EJ_DEPTH = 4;
  localparam int unsigned NCYC     = 700;

  logic                    QClk = 1'b0;
  logic                    RstQnnnL;
  logic [7:0]              CoreID;
  logic                    RingInValidQ500H;
  logic [9:0]              RequestorQ500H;
  t_opcode                 OpcodeQ500H;
  logic [31:0]             AddressQ500H;
  logic [31:0]             DataQ500H;
  logic                    RingOutValidQ502H;
  logic [9:0]              RequestorQ502H;
  t_opcode                 OpcodeQ502H;
  logic [31:0]             AddressQ502H;
  logic [31:0]             DataQ502H;
  logic [NUM_LCL-1:0]      LclValid;
  t_ring_msg [NUM_LCL-1:0] LclMsg;
  logic [NUM_LCL-1:0]      LclReady;
  logic                    EjValid;
  t_ring_msg               EjMsg;
  logic                    EjReady;
  logic                    EjFull;
`ifdef LOTR_RING_STOP_PERF_EN
  logic [15:0]             PerfInjCnt;
  logic [15:0]             PerfEjCnt;
  logic [15:0]             PerfBounceCnt;
`endif

  lotr_ring_stop #(
    .NUM_LCL         (NUM_LCL),
    .EJ_DEPTH        (EJ_DEPTH),
    .MATCH_REQUESTOR (1'b0)
  ) dut (
    .QClk              (QClk),
    .RstQnnnL          (RstQnnnL),
    .CoreID            (CoreID),
    .RingInValidQ500H  (RingInValidQ500H),
    .RequestorQ500H    (RequestorQ500H),
    .OpcodeQ500H       (OpcodeQ500H),
    .AddressQ500H      (AddressQ500H),
    .DataQ500H         (DataQ500H),
    .RingOutValidQ502H (RingOutValidQ502H),
    .RequestorQ502H    (RequestorQ502H),
    .OpcodeQ502H       (OpcodeQ502H),
    .AddressQ502H      (AddressQ502H),
    .DataQ502H         (DataQ502H),
    .LclValid          (LclValid),
    .LclMsg            (LclMsg),
    .LclReady          (LclReady),
    .EjValid           (EjValid),
    .EjMsg             (EjMsg),
    .EjReady           (EjReady),
    .EjFull            (EjFull)
`ifdef LOTR_RING_STOP_PERF_EN
    ,
    .PerfInjCnt        (PerfInjCnt),
    .PerfEjCnt         (PerfEjCnt),
    .PerfBounceCnt     (PerfBounceCnt)
`endif
  );

  always #5 QClk = ~QClk;

  typedef struct {
    t_ring_msg          ring;
    logic               ejv;
    logic               full;
    t_ring_msg          ejmsg;
    logic [NUM_LCL-1:0] ready;
    int unsigned        inj;
    int unsigned        ej;
    int unsigned        bnc;
  } t_exp;

  t_exp        exp_q[$];
  int unsigned errors = 0;
  int unsigned checks = 0;
  bit          done   = 1'b0;

  // Reference model state: last sampled ring slot, registered output slot,
  // FIFO contents as a plain queue, round-robin start channel, event counts
  t_ring_msg   m_q501;
  t_ring_msg   m_out;
  t_ring_msg   m_fifo[$];
  int unsigned m_rr;
  int unsigned m_inj, m_ej, m_bnc;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic t_ring_msg rand_msg(input logic [7:0] dest);
    t_ring_msg m;
    m.valid     = 1'($urandom);
    m.requestor = 10'($urandom);
    m.opcode    = t_opcode'(2'($urandom_range(0, 3)));
    m.address   = {dest, 24'($urandom)};
    m.data      = $urandom;
    return m;
  endfunction

  function automatic logic [7:0] rand_dest();
    return ($urandom_range(0, 9) < 4) ? 8'd3 : 8'($urandom);
  endfunction

  task automatic set_ring(input bit v, input t_ring_msg m);
    RingInValidQ500H = v;
    RequestorQ500H   = m.requestor;
    OpcodeQ500H      = m.opcode;
    AddressQ500H     = m.address;
    DataQ500H        = m.data;
  endtask

  task automatic model_reset();
    m_q501 = '0;
    m_out  = '0;
    m_fifo.delete();
    m_rr   = 0;
    m_inj  = 0;
    m_ej   = 0;
    m_bnc  = 0;
  endtask

  function automatic int unsigned sat(input int unsigned c);
    return (c < 16'hFFFF) ? c + 1 : c;
  endfunction

  // Apply this cycle's inputs according to the test phase
  task automatic drive_cycle(input int unsigned cyc);
    t_ring_msg m;
    RstQnnnL = !((cyc < 3) || (cyc >= 400 && cyc < 402));
    LclValid = '0;
    EjReady  = 1'b1;
    for (int unsigned i = 0; i < NUM_LCL; i++) LclMsg[i] = rand_msg(rand_dest());
    m = rand_msg(8'd5);
    set_ring(1'b0, m);
    if (cyc >= 3 && cyc < 19) begin
      LclValid = '1;
      if (cyc == 12) set_ring(1'b1, m);
    end else if (cyc == 20) begin
      m.address = 32'h0500_0010;
      set_ring(1'b1, m);
    end else if (cyc == 22) begin
      m.address = 32'h0300_0040;
      set_ring(1'b1, m);
    end else if (cyc >= 30 && cyc < 40) begin
      EjReady = 1'b0;
      if (cyc < 35) set_ring(1'b1, rand_msg(8'd3));
    end else if (cyc >= 40 && cyc < 48) begin
      set_ring(1'b1, rand_msg(8'd3));
    end else if (cyc >= 48) begin
      set_ring($urandom_range(0, 9) < 7, rand_msg(rand_dest()));
      LclValid = NUM_LCL'($urandom);
      EjReady  = ((cyc / 32) % 3 == 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  endtask

  // Reference behaviour for one cycle: expected visible outputs, then the
  // state seen after the next clock edge
  task automatic model_step();
    t_exp        e;
    t_ring_msg   nm;
    bit          pop, match, room, ejected, granted;
    int unsigned g, c;
    e = '{ring: '0, ejv: 1'b0, full: 1'b0, ejmsg: '0, ready: '0, inj: 0, ej: 0, bnc: 0};
    if (!RstQnnnL) begin
      model_reset();
      exp_q.push_back(e);
      return;
    end
    e.ring  = m_out;
    e.ejv   = (m_fifo.size() > 0);
    e.full  = (m_fifo.size() == EJ_DEPTH);
    if (e.ejv) e.ejmsg = m_fifo[0];
    e.inj   = m_inj;
    e.ej    = m_ej;
    e.bnc   = m_bnc;
    pop     = e.ejv && EjReady;
    match   = m_q501.valid && (m_q501.address[31:24] == CoreID);
    room    = (m_fifo.size() - (pop ? 1 : 0)) < EJ_DEPTH;
    ejected = match && room;
    granted = 1'b0;
    g       = 0;
    if (!m_q501.valid || ejected) begin
      for (int unsigned i = 0; i < NUM_LCL; i++) begin
        c = (m_rr + i) % NUM_LCL;
        if (!granted && LclValid[c]) begin
          granted = 1'b1;
          g       = c;
        end
      end
    end
    if (granted) e.ready[g] = 1'b1;
    exp_q.push_back(e);
    if (granted) begin
      nm       = LclMsg[g];
      nm.valid = 1'b1;
    end else if (m_q501.valid && !ejected) begin
      nm = m_q501;
    end else begin
      nm = '0;
    end
    if (pop) void'(m_fifo.pop_front());
    if (ejected) m_fifo.push_back(m_q501);
    if (granted) begin
      m_rr  = (g + 1) % NUM_LCL;
      m_inj = sat(m_inj);
    end
    if (ejected) m_ej = sat(m_ej);
    if (match && !room) m_bnc = sat(m_bnc);
    m_out = nm;
    m_q501 = '{valid: RingInValidQ500H, requestor: RequestorQ500H, opcode: OpcodeQ500H,
               address: AddressQ500H, data: DataQ500H};
  endtask

  // Driver: inputs on the falling edge, expected record one tick later
  initial begin
    CoreID   = 8'd3;
    RstQnnnL = 1'b0;
    LclValid = '0;
    LclMsg   = '0;
    EjReady  = 1'b0;
    set_ring(1'b0, '0);
    model_reset();
    for (int unsigned cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge QClk);
      drive_cycle(cyc);
      #1;
      model_step();
    end
    #3;
    done = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d records left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Monitor: one expected record per cycle, compared mid-cycle
  initial begin
    t_exp e;
    forever begin
      @(negedge QClk);
      #2;
      if (!done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty at %0t: got no record expected one", $time);
        end else begin
          e = exp_q.pop_front();
          chk("ring_valid", 96'(RingOutValidQ502H), 96'(e.ring.valid));
          if (e.ring.valid)
            chk("ring_msg", 96'({RequestorQ502H, OpcodeQ502H, AddressQ502H, DataQ502H}),
                96'({e.ring.requestor, e.ring.opcode, e.ring.address, e.ring.data}));
          chk("ej_valid", 96'(EjValid), 96'(e.ejv));
          chk("ej_full", 96'(EjFull), 96'(e.full));
          if (e.ejv) chk("ej_msg", 96'(EjMsg), 96'(e.ejmsg));
          chk("lcl_ready", 96'(LclReady), 96'(e.ready));
`ifdef LOTR_RING_STOP_PERF_EN
          chk("perf_inj", 96'(PerfInjCnt), 96'(e.inj));
          chk("perf_ej", 96'(PerfEjCnt), 96'(e.ej));
          chk("perf_bounce", 96'(PerfBounceCnt), 96'(e.bnc));
`endif
        end
      end
    end
  end

endmodule
